// File: rtl/regbank_bus_arbiter_pkg.sv
// regbank_bus_arbiter_pkg: FSM encodings and sizing helper shared by the arbiter files
package regbank_bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_t;
  function automatic int addr_bits_for(input int nr_of_regs);
    return (nr_of_regs > 1) ? $clog2(nr_of_regs) : 1;
  endfunction
endpackage

// File: rtl/regbank_bus_arbiter_if.sv
// regbank_bus_arbiter_if: requester-side and bank-side signals of the register bank arbiter
interface regbank_bus_arbiter_if #(
  parameter int NrOfReq  = 4,
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3,
  parameter int NrOfBits = 32
);
  logic [NrOfReq-1:0]          Req;
  logic [NrOfReq-1:0]          Wr;
  logic [NrOfReq*AddrBits-1:0] Addr;
  logic [NrOfReq*NrOfBits-1:0] WData;
  logic [NrOfReq-1:0]          Grant;
  logic [NrOfReq-1:0]          Done;
  logic                        Err;
  logic [NrOfBits-1:0]         RData;
  logic [NrOfRegs-1:0]         RegCe;
  logic                        RegTick;
  logic [NrOfRegs-1:0]         RegCs;
  logic [NrOfBits-1:0]         BusWData;
  logic [NrOfBits-1:0]         BusRData;
  modport master (
    output Req, Wr, Addr, WData, BusRData,
    input  Grant, Done, Err, RData, RegCe, RegTick, RegCs, BusWData
  );
  modport slave (
    input  Req, Wr, Addr, WData, BusRData,
    output Grant, Done, Err, RData, RegCe, RegTick, RegCs, BusWData
  );
endinterface

// File: rtl/regbank_bus_arbiter_rr_priority_picker.sv
// rr_priority_picker: first asserted request scanning upward from ptr, wrapping modulo NrOfReq
module rr_priority_picker #(
  parameter int NrOfReq = 4,
  parameter int IdxBits = $clog2(NrOfReq)
) (
  input  logic [NrOfReq-1:0] req,
  input  logic [IdxBits-1:0] ptr,
  output logic [IdxBits-1:0] winner,
  output logic               valid
);
  // Scan from the farthest offset down so the nearest request is assigned last and wins.
  always_comb begin
    winner = '0;
    for (int i = NrOfReq - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NrOfReq]) winner = IdxBits'((int'(ptr) + i) % NrOfReq);
  end
  assign valid = |req;
endmodule

// File: rtl/regbank_bus_arbiter.sv
// regbank_bus_arbiter: round-robin sequencer granting one requester a single register read or write
module regbank_bus_arbiter
  import regbank_bus_arbiter_pkg::*;
#(
  parameter int NrOfReq  = 4,
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3,
  parameter int NrOfBits = 32
) (
  input logic Clock,
  input logic Reset,
  regbank_bus_arbiter_if.slave bus
);
  localparam int IdxBits = $clog2(NrOfReq);
  if (AddrBits < addr_bits_for(NrOfRegs)) begin : g_addr_bits_check
    $error("AddrBits too narrow to index NrOfRegs registers");
  end
  state_t state, state_nxt;
  logic [IdxBits-1:0] ptr, winner, win_q;
  logic valid, wr_q, err_q, in_range, write_hit, read_hit;
  logic [AddrBits-1:0] addr_q;
  logic [NrOfBits-1:0] wdata_q, rdata_q;
  logic [NrOfReq-1:0] owner;
  logic [NrOfRegs-1:0] reg_sel;
  rr_priority_picker #(.NrOfReq(NrOfReq)) u_picker (
    .req(bus.Req),
    .ptr(ptr),
    .winner(winner),
    .valid(valid)
  );
  assign in_range = int'(addr_q) < NrOfRegs;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && valid) begin
        win_q   <= winner;
        wr_q    <= bus.Wr[winner];
        addr_q  <= bus.Addr[winner*AddrBits +: AddrBits];
        wdata_q <= bus.WData[winner*NrOfBits +: NrOfBits];
      end
      // Writes and out-of-range accesses report zero data; reads capture the bank bus.
      if (state == ST_ACCESS) begin
        err_q   <= !in_range;
        rdata_q <= (in_range && !wr_q) ? bus.BusRData : '0;
      end
      if (state == ST_RESP) ptr <= (int'(win_q) == NrOfReq - 1) ? '0 : win_q + 1'b1;
    end
  end
  always_comb begin
    state_nxt    = state == ST_IDLE ? (valid ? ST_ACCESS : ST_IDLE) :
                   state == ST_ACCESS ? ST_RESP : ST_IDLE;
    owner        = NrOfReq'(1) << win_q;
    reg_sel      = NrOfRegs'(1) << addr_q;
    write_hit    = state == ST_ACCESS && wr_q && in_range;
    read_hit     = state == ST_ACCESS && !wr_q && in_range;
    bus.Grant    = state != ST_IDLE ? owner : '0;
    bus.Done     = state == ST_RESP ? owner : '0;
    bus.Err      = state == ST_RESP && err_q;
    bus.RData    = rdata_q;
    bus.RegTick  = write_hit;
    bus.RegCe    = write_hit ? reg_sel : '0;
    bus.BusWData = write_hit ? wdata_q : '0;
    bus.RegCs    = read_hit ? ~reg_sel : '1;
  end
endmodule

// File: tb/tb_regbank_bus_arbiter.sv
// tb_regbank_bus_arbiter: scoreboard bench with a bank model and a round-robin reference model
module tb_regbank_bus_arbiter;
  localparam int NR = 4;
  localparam int NREGS = 6;
  localparam int AB = 3;
  localparam int NB = 32;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;
  regbank_bus_arbiter_if #(.NrOfReq(NR), .NrOfRegs(NREGS), .AddrBits(AB), .NrOfBits(NB)) bus ();
  regbank_bus_arbiter #(.NrOfReq(NR), .NrOfRegs(NREGS), .AddrBits(AB), .NrOfBits(NB)) u_dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus.slave)
  );
  typedef struct {
    int          winner;
    bit          wr;
    int          addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;
  txn_t exp_q[$];
  txn_t cur;
  bit have = 0;
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  logic [31:0] bank [NREGS] = '{default: 32'h0};
  logic [31:0] mbank [NREGS] = '{default: 32'h0};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Register bank: captures on Tick with its own ClockEnable, drives the read bus when selected.
  always @(posedge Clock)
    for (int i = 0; i < NREGS; i++)
      if (bus.RegCe[i] && bus.RegTick) bank[i] <= bus.BusWData;
  always_comb begin
    bus.BusRData = 32'hBAD0_BAD0;
    for (int i = 0; i < NREGS; i++)
      if (!bus.RegCs[i]) bus.BusRData = bank[i];
  end
  always @(negedge Clock) begin : monitor
    logic [NREGS-1:0] exp_ce, exp_cs;
    if (Reset) begin
      if (bus.Grant != 0 && bus.Done == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got grant %b expected no transaction", bus.Grant);
        end else begin
          cur = exp_q.pop_front();
          have = 1;
          exp_ce = '0;
          exp_cs = '1;
          if (cur.addr < NREGS && cur.wr) exp_ce[cur.addr] = 1'b1;
          if (cur.addr < NREGS && !cur.wr) exp_cs[cur.addr] = 1'b0;
          chk("access_grant", bus.Grant, 64'(1 << cur.winner));
          chk("access_regce", bus.RegCe, exp_ce);
          chk("access_regcs", bus.RegCs, exp_cs);
          chk("access_tick", bus.RegTick, exp_ce != 0);
          if (exp_ce != 0) chk("access_buswdata", bus.BusWData, cur.wdata);
        end
      end else if (bus.Done != 0) begin
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done %b expected no transaction", bus.Done);
        end else begin
          chk("resp_done", bus.Done, 64'(1 << cur.winner));
          chk("resp_grant", bus.Grant, 64'(1 << cur.winner));
          chk("resp_err", bus.Err, cur.err);
          chk("resp_rdata", bus.RData, cur.rdata);
          chk("resp_regce", bus.RegCe, 0);
          chk("resp_regcs", bus.RegCs, {NREGS{1'b1}});
          have = 0;
        end
      end else begin
        chk("idle_regce", bus.RegCe, 0);
        chk("idle_regcs", bus.RegCs, {NREGS{1'b1}});
        chk("idle_tick", bus.RegTick, 0);
        chk("idle_err", bus.Err, 0);
      end
    end
  end
  function automatic int pick(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++)
      if (r[(mptr + k) % NR]) return (mptr + k) % NR;
    return -1;
  endfunction
  task automatic reset_vals(input string tag);
    chk({tag, "_grant"}, bus.Grant, 0);
    chk({tag, "_done"}, bus.Done, 0);
    chk({tag, "_err"}, bus.Err, 0);
    chk({tag, "_rdata"}, bus.RData, 0);
    chk({tag, "_regce"}, bus.RegCe, 0);
    chk({tag, "_tick"}, bus.RegTick, 0);
    chk({tag, "_buswdata"}, bus.BusWData, 0);
    chk({tag, "_regcs"}, bus.RegCs, {NREGS{1'b1}});
  endtask
  // One arbitration slot: drive inputs before the IDLE edge, then optionally disturb them
  // during ACCESS/RESP (mode 1 random, mode 2 all requests dropped).
  task automatic issue(input logic [NR-1:0] r, input logic [NR-1:0] w,
                       input logic [NR*AB-1:0] a, input logic [NR*NB-1:0] d, input int mode);
    txn_t t;
    @(negedge Clock);
    bus.Req = r;
    bus.Wr = w;
    bus.Addr = a;
    bus.WData = d;
    if (r == 0) begin
      @(posedge Clock);
      return;
    end
    t.winner = pick(r);
    mptr = (t.winner + 1) % NR;
    t.wr = w[t.winner];
    t.addr = int'(a[t.winner*AB +: AB]);
    t.wdata = d[t.winner*NB +: NB];
    t.err = t.addr >= NREGS;
    t.rdata = 32'h0;
    if (!t.err) begin
      if (t.wr) mbank[t.addr] = t.wdata;
      else t.rdata = mbank[t.addr];
    end
    exp_q.push_back(t);
    @(posedge Clock);
    #1;
    if (mode == 1) begin
      bus.Req = NR'($urandom);
      bus.Wr = NR'($urandom);
      bus.Addr = (NR*AB)'($urandom);
      bus.WData = {$urandom, $urandom, $urandom, $urandom};
    end else if (mode == 2) bus.Req = '0;
    @(posedge Clock);
    @(posedge Clock);
  endtask
  initial begin
    repeat (20000) @(posedge Clock);
    $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.Req = '0;
    bus.Wr = '0;
    bus.Addr = '0;
    bus.WData = '0;
    repeat (2) @(negedge Clock);
    reset_vals("reset");
    Reset = 1'b1;
    mptr = 0;
    issue(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, {96'h0, 32'hDEADBEEF}, 0);
    chk("bank3_written", bank[3], 32'hDEADBEEF);
    issue(4'b0100, 4'b0000, {3'd0, 3'd3, 3'd0, 3'd0}, '0, 0);
    issue(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd7}, '0, 0);
    issue(4'b0010, 4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, {64'h0, 32'h1234_5678, 32'h0}, 2);
    issue(4'b1111, 4'b0000, {3'd5, 3'd5, 3'd5, 3'd5}, '0, 0);
    // Abort a write to register 1 during ACCESS; the bank must keep its old value.
    @(negedge Clock);
    bus.Req = 4'b0100;
    bus.Wr = 4'b0100;
    bus.Addr = {3'd0, 3'd1, 3'd0, 3'd0};
    bus.WData = {32'h0, 32'hA5A5_A5A5, 64'h0};
    @(posedge Clock);
    #1;
    chk("abort_pre_regce", bus.RegCe, 6'b000010);
    Reset = 1'b0;
    #1;
    reset_vals("abort");
    bus.Req = '0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    mptr = 0;
    for (int n = 0; n < 5; n++)
      issue(4'b1111, 4'($urandom), 12'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0);
    issue(4'b0010, 4'b0000, {3'd0, 3'd0, 3'd1, 3'd0}, '0, 0);
    for (int n = 0; n < 400; n++)
      issue(4'($urandom), 4'($urandom), 12'($urandom), {$urandom, $urandom, $urandom, $urandom},
            int'($urandom_range(0, 2)));
    bus.Req = '0;
    repeat (5) @(negedge Clock);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_inflight", have, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
